// File: rtl/cache_l1_param.sv
// -----------------------------------------------------------------------------
// cache_l1_param
// Direct-mapped, write-back, write-allocate L1 cache with a one-word-per-
// handshake L2 interface. Misses write back a dirty victim in ascending word
// order, then fill critical-word-first. The access is then completed as an
// ordinary hit in IDLE.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite   CPU request (both high = write)
//   addr, wdata         CPU word address and write data
//   rdata               read data, valid on a read hit in IDLE, else 0
//   hit                 combinational lookup hit for addr
//   IsStall             CPU must hold its request
//   l2_req, l2_we       L2 word request; 1 = writeback, 0 = fill
//   l2_addr, l2_wdata   L2 word address and writeback data
//   l2_ack, l2_rdata    L2 word done; fill data valid with the ack
//   hit_cnt, miss_cnt   saturating performance counters
// -----------------------------------------------------------------------------
module cache_l1_param #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 4,
   parameter int WORDS  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              hit,
   output logic              IsStall,
   output logic              l2_req,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [DATA_W-1:0] l2_wdata,
   input  logic              l2_ack,
   input  logic [DATA_W-1:0] l2_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

   state_t state, state_nx;

   // Line state and storage
   logic [SETS-1:0]   valid;
   logic [SETS-1:0]   dirty;
   logic [TAG_W-1:0]  tag_arr  [SETS];
   logic [DATA_W-1:0] data_arr [SETS][WORDS];

   // Word counter shared by writeback and fill; wraps modulo WORDS
   logic [OFF_W-1:0]  k;
   // Set on a miss, cleared when the access later completes as a hit, so
   // the completing hit is not counted in hit_cnt
   logic              missed;

   // Address split
   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [OFF_W-1:0]  fill_off;
   logic              req;
   logic              last_word;
   logic              idle_hit;
   logic              idle_miss;

   assign off       = addr[OFF_W-1:0];
   assign idx       = addr[OFF_W +: IDX_W];
   assign tag       = addr[ADDR_W-1 -: TAG_W];
   assign fill_off  = off + k;
   assign req       = MemRead | MemWrite;
   assign last_word = (k == '1);

   assign hit       = valid[idx] && (tag_arr[idx] == tag);
   assign idle_hit  = (state == IDLE) && req && hit;
   assign idle_miss = (state == IDLE) && req && !hit;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top keeps every path assigned, so no
   // latch is inferred for state_nx.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (idle_miss) state_nx = (valid[idx] && dirty[idx]) ? WB : FILL;
         WB:   if (l2_ack && last_word) state_nx = FILL;
         FILL: if (l2_ack && last_word) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      l2_req   = 1'b0;
      l2_we    = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
      rdata    = '0;
      IsStall  = req && !((state == IDLE) && hit);
      unique case (state)
         IDLE: if (hit && MemRead && !MemWrite) rdata = data_arr[idx][off];
         WB: begin
            l2_req   = 1'b1;
            l2_we    = 1'b1;
            l2_addr  = {tag_arr[idx], idx, k};
            l2_wdata = data_arr[idx][k];
         end
         FILL: begin
            l2_req  = 1'b1;
            l2_addr = {tag, idx, fill_off};
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Line status, word counter and performance counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= '0;
         dirty    <= '0;
         k        <= '0;
         missed   <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if ((state == WB || state == FILL) && l2_ack) k <= k + 1'b1;
         else if (state == IDLE)                      k <= '0;

         if (state == FILL && l2_ack && last_word) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (idle_hit && MemWrite) begin
            dirty[idx] <= 1'b1;
         end

         if (idle_hit) begin
            missed <= 1'b0;
            if (!missed && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
         end

         if (idle_miss) begin
            missed <= 1'b1;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Tag and data arrays
   // ---------------------------------------------------------------------------
   // NOTE: storage arrays carry no reset; valid bits gate their use, and
   // leaving them unreset lets synthesis map them onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (state == FILL && l2_ack) begin
         data_arr[idx][fill_off] <= l2_rdata;
         if (last_word) tag_arr[idx] <= tag;
      end else if (idle_hit && MemWrite) begin
         data_arr[idx][off] <= wdata;
      end
   end

endmodule

// File: tb/tb_cache_l1_param.sv
// -----------------------------------------------------------------------------
// tb_cache_l1_param
// Directed bench for cache_l1_param with default parameters. The L2 side is
// driven word by word from tasks; fill data is {16'hA5A5, addr[15:0]}.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_cache_l1_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        hit;
   logic        IsStall;
   logic        l2_req;
   logic        l2_we;
   logic [31:0] l2_addr;
   logic [31:0] l2_wdata;
   logic        l2_ack = 1'b0;
   logic [31:0] l2_rdata = '0;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int vectors = 0;
   int miscompares = 0;

   cache_l1_param dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .IsStall(IsStall),
      .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_ack(l2_ack), .l2_rdata(l2_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fill_word(input logic [31:0] a);
      return {16'hA5A5, a[15:0]};
   endfunction

   // One L2 word: optional wait cycles with ack low, then the acked word.
   task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int waits);
      for (int w = 0; w < waits; w++) begin
         @(negedge clk); l2_ack = 1'b0; #1;
         vectors++;
         if (l2_req !== 1'b1 || l2_addr !== a || l2_we !== we || IsStall !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_stable: req=%b we=%b addr=%h stall=%b, want req=1 we=%b addr=%h stall=1",
                     l2_req, l2_we, l2_addr, IsStall, we, a);
         end
      end
      @(negedge clk); #1;
      vectors++;
      if (l2_req !== 1'b1 || l2_we !== we || l2_addr !== a || IsStall !== 1'b1) begin
         miscompares++;
         $display("FAIL l2_word: req=%b we=%b addr=%h stall=%b, want req=1 we=%b addr=%h stall=1",
                  l2_req, l2_we, l2_addr, IsStall, we, a);
      end
      if (we) begin
         vectors++;
         if (l2_wdata !== wd) begin
            miscompares++;
            $display("FAIL wb_data@%h: got %h want %h", a, l2_wdata, wd);
         end
      end
      l2_ack   = 1'b1;
      l2_rdata = we ? 32'h0 : fill_word(a);
      @(posedge clk); #1;
      l2_ack   = 1'b0;
   endtask

   // DONE cycle, then the completing hit in IDLE; request dropped afterwards.
   task automatic finish_access(input logic is_read, input logic [31:0] exp_rdata);
      @(negedge clk); #1;
      vectors++;
      if (IsStall !== 1'b1 || l2_req !== 1'b0) begin
         miscompares++;
         $display("FAIL done_cycle: stall=%b req=%b, want stall=1 req=0", IsStall, l2_req);
      end
      @(negedge clk); #1;
      vectors++;
      if (hit !== 1'b1 || IsStall !== 1'b0 || rdata !== (is_read ? exp_rdata : 32'h0)) begin
         miscompares++;
         $display("FAIL complete: hit=%b stall=%b rdata=%h, want hit=1 stall=0 rdata=%h",
                  hit, IsStall, rdata, is_read ? exp_rdata : 32'h0);
      end
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
   endtask

   task automatic start_miss(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
      #1;
      vectors++;
      if (hit !== 1'b0 || IsStall !== 1'b1 || l2_req !== 1'b0) begin
         miscompares++;
         $display("FAIL miss_start@%h: hit=%b stall=%b req=%b, want 0 1 0", a, hit, IsStall, l2_req);
      end
   endtask

   // Single-cycle hit access in IDLE.
   task automatic hit_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rdata);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
      #1;
      vectors++;
      if (hit !== 1'b1 || IsStall !== 1'b0 || rdata !== exp_rdata) begin
         miscompares++;
         $display("FAIL hit@%h: hit=%b stall=%b rdata=%h, want hit=1 stall=0 rdata=%h",
                  a, hit, IsStall, rdata, exp_rdata);
      end
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
   endtask

   task automatic check_counts(input string name, input int h, input int m);
      vectors++;
      if (hit_cnt !== 16'(h) || miss_cnt !== 16'(m)) begin
         miscompares++;
         $display("FAIL %s: hit_cnt=%0d miss_cnt=%0d, want %0d %0d", name, hit_cnt, miss_cnt, h, m);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (l2_req !== 1'b0 || l2_we !== 1'b0 || l2_addr !== 32'h0 || l2_wdata !== 32'h0 ||
          IsStall !== 1'b0 || rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h stall=%b rdata=%h, want all 0",
                  l2_req, l2_we, l2_addr, l2_wdata, IsStall, rdata);
      end
      check_counts("reset_counts", 0, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_read_miss();
      start_miss(1'b1, 1'b0, 32'h12, 32'h0);
      xfer(1'b0, 32'h12, 32'h0, 0);
      xfer(1'b0, 32'h13, 32'h0, 0);
      xfer(1'b0, 32'h10, 32'h0, 0);
      xfer(1'b0, 32'h11, 32'h0, 0);
      finish_access(1'b1, 32'hA5A50012);
      check_counts("read_miss_counts", 0, 1);
   endtask

   task automatic test_read_hit();
      hit_access(1'b1, 1'b0, 32'h12, 32'h0, 32'hA5A50012);
      check_counts("read_hit_counts", 1, 1);
   endtask

   task automatic test_writeback();
      hit_access(1'b1, 1'b1, 32'h11, 32'hDEADBEEF, 32'h0);
      check_counts("write_hit_counts", 2, 1);
      start_miss(1'b1, 1'b0, 32'h21, 32'h0);
      xfer(1'b1, 32'h10, 32'hA5A50010, 0);
      xfer(1'b1, 32'h11, 32'hDEADBEEF, 0);
      xfer(1'b1, 32'h12, 32'hA5A50012, 0);
      xfer(1'b1, 32'h13, 32'hA5A50013, 0);
      xfer(1'b0, 32'h21, 32'h0, 0);
      xfer(1'b0, 32'h22, 32'h0, 0);
      xfer(1'b0, 32'h23, 32'h0, 0);
      xfer(1'b0, 32'h20, 32'h0, 0);
      finish_access(1'b1, 32'hA5A50021);
      check_counts("writeback_counts", 2, 2);
   endtask

   // Write miss to an invalid line, then eviction of that dirty line with a
   // five-cycle L2 wait in the middle of the next fill.
   task automatic test_write_miss_and_wait();
      start_miss(1'b0, 1'b1, 32'h35, 32'hCAFEF00D);
      xfer(1'b0, 32'h35, 32'h0, 0);
      xfer(1'b0, 32'h36, 32'h0, 0);
      xfer(1'b0, 32'h37, 32'h0, 0);
      xfer(1'b0, 32'h34, 32'h0, 0);
      finish_access(1'b0, 32'h0);
      check_counts("write_miss_counts", 2, 3);
      hit_access(1'b1, 1'b0, 32'h35, 32'h0, 32'hCAFEF00D);
      start_miss(1'b1, 1'b0, 32'h75, 32'h0);
      xfer(1'b1, 32'h34, 32'hA5A50034, 0);
      xfer(1'b1, 32'h35, 32'hCAFEF00D, 0);
      xfer(1'b1, 32'h36, 32'hA5A50036, 0);
      xfer(1'b1, 32'h37, 32'hA5A50037, 0);
      xfer(1'b0, 32'h75, 32'h0, 0);
      xfer(1'b0, 32'h76, 32'h0, 5);
      xfer(1'b0, 32'h77, 32'h0, 0);
      xfer(1'b0, 32'h74, 32'h0, 0);
      finish_access(1'b1, 32'hA5A50075);
      check_counts("evict_counts", 3, 4);
   endtask

   task automatic test_reset_mid_fill();
      start_miss(1'b1, 1'b0, 32'h41, 32'h0);
      xfer(1'b0, 32'h41, 32'h0, 0);
      xfer(1'b0, 32'h42, 32'h0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (l2_req !== 1'b0 || l2_addr !== 32'h0 || hit !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_fill: req=%b addr=%h hit=%b, want 0 0 0", l2_req, l2_addr, hit);
      end
      check_counts("reset_mid_counts", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (hit !== 1'b0 || IsStall !== 1'b1) begin
         miscompares++;
         $display("FAIL reread_miss: hit=%b stall=%b, want 0 1", hit, IsStall);
      end
      xfer(1'b0, 32'h41, 32'h0, 0);
      xfer(1'b0, 32'h42, 32'h0, 0);
      xfer(1'b0, 32'h43, 32'h0, 0);
      xfer(1'b0, 32'h40, 32'h0, 0);
      finish_access(1'b1, 32'hA5A50041);
      check_counts("refill_counts", 0, 1);
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_writeback();
      test_write_miss_and_wait();
      test_reset_mid_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_l1_param.md
CACHE_L1_PARAM -- requirements
Module: cache_l1_param

Interface
REQ-001 The block SHALL be parameterised as follows (name, default, meaning):
 - ADDR_W, 32: word-address width.
 - DATA_W, 32: word width.
 - SETS, 4: number of lines, power of two, at least 2.
 - WORDS, 4: words per line, power of two, at least 2.
 - CNT_W, 16: width of the performance counters.
REQ-002 Address split SHALL be: offset = addr[log2(WORDS)-1:0], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-003 The ports SHALL be (name, direction, width, meaning):
 - clk, in, 1: single clock, rising edge.
 - rst, in, 1: asynchronous, active-high reset.
 - MemRead, in, 1: CPU read request.
 - MemWrite, in, 1: CPU write request.
 - addr, in, ADDR_W: CPU word address.
 - wdata, in, DATA_W: CPU write data.
 - rdata, out, DATA_W: CPU read data.
 - hit, out, 1: lookup hit for the current addr.
 - IsStall, out, 1: CPU must hold its request.
 - l2_req, out, 1: L2 transfer request, one word per handshake.
 - l2_we, out, 1: 1 = writeback word, 0 = fill word.
 - l2_addr, out, ADDR_W: L2 word address.
 - l2_wdata, out, DATA_W: writeback data.
 - l2_ack, in, 1: L2 completed the current word; l2_rdata is valid in the same cycle when l2_we = 0.
 - l2_rdata, in, DATA_W: fill data.
 - hit_cnt, out, CNT_W: saturating count of hits.
 - miss_cnt, out, CNT_W: saturating count of misses.

Function
REQ-004 The cache SHALL be direct-mapped, write-back and write-allocate, with per-line valid bit, dirty bit and tag.
REQ-005 hit SHALL equal valid[index] AND (stored tag == tag), and SHALL be combinational.
REQ-006 On a read hit in IDLE:
 - rdata SHALL be the addressed word in the same cycle.
 - IsStall SHALL be 0.
 - When no read hit is present, rdata SHALL be 0.
REQ-007 On a write hit in IDLE, the addressed word SHALL be written and dirty set at the next rising clk edge, with IsStall = 0.
REQ-008 If MemRead and MemWrite are both 1, the access SHALL be treated as a write and no read data returned.
REQ-009 IsStall SHALL equal (MemRead OR MemWrite) AND NOT (state == IDLE AND hit), combinationally.
REQ-010 The CPU SHALL hold addr, wdata, MemRead and MemWrite stable while IsStall = 1; behaviour is undefined otherwise.
REQ-011 The FSM SHALL have states IDLE, WB, FILL and DONE.
 - IDLE to WB: on a miss with the victim line valid and dirty.
 - IDLE to FILL: on a miss with the victim line invalid or clean.
 - WB to FILL: on the ack of the last writeback word.
 - FILL to DONE: on the ack of the last fill word.
 - DONE to IDLE: unconditionally, after one cycle.
REQ-012 In WB:
 - l2_req = 1 and l2_we = 1.
 - l2_addr SHALL be {victim tag, index, k} for k = 0 to WORDS-1 ascending.
 - l2_wdata SHALL be stored word k.
 - k SHALL advance only on l2_ack.
REQ-013 In FILL, fill order SHALL be critical-word-first:
 - l2_req = 1 and l2_we = 0.
 - l2_addr SHALL be {tag, index, (offset+k) mod WORDS}, with k wrapping to 0 modulo WORDS.
 - Each l2_ack SHALL write l2_rdata into that word.
REQ-014 On the last fill ack, the tag SHALL be written, valid set to 1 and dirty cleared.
REQ-015 The access SHALL complete as a hit in IDLE on the cycle after DONE.
REQ-016 l2_req, l2_we and l2_addr SHALL be held stable until l2_ack, for any number of wait cycles.
REQ-017 In IDLE and DONE, l2_req SHALL be 0.
REQ-018 hit_cnt SHALL increment once per completed IDLE access that hits without any preceding miss.
REQ-019 miss_cnt SHALL increment once per IDLE-to-WB or IDLE-to-FILL transition.
REQ-020 hit_cnt and miss_cnt SHALL saturate at all-ones.

Reset
REQ-021 While rst = 1, asynchronously, the block SHALL:
 - clear all valid and dirty bits;
 - force the FSM to IDLE;
 - clear the word counter k, hit_cnt and miss_cnt;
 - drive l2_req, l2_we, l2_addr and l2_wdata to 0.
REQ-022 Reset during WB or FILL SHALL abandon the transfer, leaving the line invalid; data arrays need no reset.
REQ-023 After reset, every access SHALL miss.

Verification
REQ-024 The bench SHALL cover the following scenarios, with default parameters:
 - Reset, then MemRead addr=0x12 → IsStall=1; no WB; fill l2_addr order 0x12, 0x13, 0x10, 0x11; DONE; then hit=1, rdata equals the L2 word at 0x12, miss_cnt=1.
 - Repeat read of 0x12 → same-cycle rdata, IsStall=0, hit_cnt=1.
 - MemWrite 0x11 with 0xDEADBEEF, then MemRead 0x21 → WB of 0x10..0x13 with l2_wdata=0xDEADBEEF at 0x11, then fill 0x21, 0x22, 0x23, 0x20.
 - Write miss to a clean/invalid line 0x35 → no WB; fill 0x35, 0x36, 0x37, 0x34; the write lands after DONE; dirty=1; a later eviction writes it back.
 - l2_ack held low 5 cycles mid-FILL → l2_req/l2_addr stable throughout; IsStall stays 1.
 - rst pulsed after the 2nd fill ack → l2_req=0 immediately, counters 0; a re-read of the same address misses and restarts the fill at the critical word.
